// File: rtl/uart_stim_gen.sv
// Multi-channel UART frame generator for self-test and bench stimulus.
// One uart_stim_ch lane per TX line; lanes share config inputs but latch them independently.

module uart_stim_ch #(
  parameter int         DIV_W  = 16,
  parameter int         GAP_W  = 16,
  parameter int         CNT_W  = 16,
  parameter logic [7:0] CH_OFS = 8'd0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       start_char_i,
  input  logic [7:0]       seq_len_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             stop2_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] frame_cnt_o
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP} state_e;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [GAP_W-1:0] gap;
    logic [1:0]       mode;
    logic             par_en;
    logic             par_odd;
    logic             stop2;
    logic [7:0]       data;
  } frame_t;

  state_e           state_q, state_d;
  frame_t           frm_q, frm_d, frm_new;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_c;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       idx_q, idx_d, lfsr_q, lfsr_d;
  logic [7:0]       base, seed, seq_last;
  logic             seed_pend_q, seed_pend_d;
  logic [1:0]       mode_prev_q, mode_prev_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             bit_end, last_stop, launch, reseed;

  // Fibonacci form of x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // LFSR seeding is deferred to the first cycle after reset so the seed can follow start_char_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frm_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      bit_q       <= '0;
      idx_q       <= '0;
      lfsr_q      <= 8'h01;
      seed_pend_q <= 1'b1;
      mode_prev_q <= '0;
      fcnt_q      <= '0;
    end else begin
      frm_q       <= frm_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      bit_q       <= bit_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
      seed_pend_q <= seed_pend_d;
      mode_prev_q <= mode_prev_d;
      fcnt_q      <= fcnt_d;
    end
  end

  // Pattern state; idx/lfsr advance on the final stop cycle so a back-to-back latch sees the new value
  always_comb begin
    base      = start_char_i + CH_OFS;
    seed      = (base == 8'd0) ? 8'h01 : base;
    reseed    = seed_pend_q || (mode_i == 2'd1 && mode_prev_q != 2'd1);
    seq_last  = (seq_len_i == 8'd0) ? 8'd0 : seq_len_i - 8'd1;
    bit_end   = (cnt_q == '0);
    last_stop = (state_q == S_STOP) && bit_end && (!frm_q.stop2 || bit_q[0]);
    idx_d     = idx_q;
    if (last_stop && (frm_q.mode == 2'd0 || frm_q.mode == 2'd3))
      idx_d = (idx_q == seq_last) ? 8'd0 : idx_q + 8'd1;
    lfsr_d = lfsr_q;
    if (reseed)                              lfsr_d = seed;
    else if (last_stop && frm_q.mode == 2'd1) lfsr_d = lfsr_step(lfsr_q);
    div_c           = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
    frm_new.div     = div_c;
    frm_new.gap     = gap_i;
    frm_new.mode    = mode_i;
    frm_new.par_en  = parity_en_i;
    frm_new.par_odd = parity_odd_i;
    frm_new.stop2   = stop2_i;
    case (mode_i)
      2'd1:    frm_new.data = lfsr_d;
      2'd2:    frm_new.data = base;
      default: frm_new.data = base + idx_d;
    endcase
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE:  launch = en_i;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && bit_q == 3'd7) state_d = frm_q.par_en ? S_PAR : S_STOP;
      S_PAR:   if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (last_stop) begin
          if (frm_q.gap != '0) state_d = S_GAP;
          else if (en_i)       launch  = 1'b1;
          else                 state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          if (en_i) launch  = 1'b1;
          else      state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) state_d = S_START;
  end

  always_comb begin
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    bit_d       = bit_q;
    frm_d       = frm_q;
    seed_pend_d = 1'b0;
    mode_prev_d = mode_i;
    fcnt_d      = fcnt_q + CNT_W'(last_stop);
    if (state_q != S_IDLE && state_q != S_GAP)
      cnt_d = bit_end ? frm_q.div - DIV_W'(1) : cnt_q - DIV_W'(1);
    // bit_q wraps 7->0 leaving DATA, so STOP counts its bits from 0
    if ((state_q == S_DATA || state_q == S_STOP) && bit_end) bit_d = bit_q + 3'd1;
    if (last_stop)              gap_d = frm_q.gap - GAP_W'(1);
    else if (state_q == S_GAP)  gap_d = gap_q - GAP_W'(1);
    if (launch) begin
      frm_d = frm_new;
      cnt_d = div_c - DIV_W'(1);
      bit_d = '0;
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = frm_q.data[bit_q];
      S_PAR:   tx_o = (^frm_q.data) ^ frm_q.par_odd;
      default: tx_o = 1'b1;
    endcase
    busy_o       = (state_q != S_IDLE);
    frame_done_o = last_stop;
    frame_cnt_o  = fcnt_q;
  end
endmodule

module uart_stim_gen #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16,
  parameter int GAP_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [DIV_W-1:0]        div_i,
  input  logic [GAP_W-1:0]        gap_i,
  input  logic [1:0]              mode_i,
  input  logic [7:0]              start_char_i,
  input  logic [7:0]              seq_len_i,
  input  logic                    parity_en_i,
  input  logic                    parity_odd_i,
  input  logic                    stop2_i,
  output logic [NUM_CH-1:0]       tx_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       frame_done_o,
  output logic [NUM_CH*CNT_W-1:0] frame_cnt_o
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    uart_stim_ch #(
      .DIV_W (DIV_W),
      .GAP_W (GAP_W),
      .CNT_W (CNT_W),
      .CH_OFS(8'(g))
    ) u_ch (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .en_i        (en_i[g]),
      .div_i       (div_i),
      .gap_i       (gap_i),
      .mode_i      (mode_i),
      .start_char_i(start_char_i),
      .seq_len_i   (seq_len_i),
      .parity_en_i (parity_en_i),
      .parity_odd_i(parity_odd_i),
      .stop2_i     (stop2_i),
      .tx_o        (tx_o[g]),
      .busy_o      (busy_o[g]),
      .frame_done_o(frame_done_o[g]),
      .frame_cnt_o (frame_cnt_o[g*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_uart_stim_gen.sv
// Bench for uart_stim_gen: a software UART receiver per line decodes frames and
// compares them with a spec-level pattern model; table-driven and random configs.

module tb_uart_stim_gen;
  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int GW  = 16;
  localparam int CW  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   en = '0;
  logic [DW-1:0]    div = 16'd4;
  logic [GW-1:0]    gap = '0;
  logic [1:0]       mode = '0;
  logic [7:0]       start = 8'h41;
  logic [7:0]       slen = 8'd26;
  logic             pe = 1'b0, po = 1'b0, s2 = 1'b0;
  logic [NCH-1:0]   tx, busy, done;
  logic [NCH*CW-1:0] fcnt;

  always #5 clk = ~clk;

  uart_stim_gen #(.NUM_CH(NCH), .DIV_W(DW), .GAP_W(GW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .div_i(div), .gap_i(gap), .mode_i(mode),
    .start_char_i(start), .seq_len_i(slen), .parity_en_i(pe), .parity_odd_i(po),
    .stop2_i(s2), .tx_o(tx), .busy_o(busy), .frame_done_o(done), .frame_cnt_o(fcnt)
  );

  typedef struct {
    int div; bit pe; bit po; bit s2; int gap; int mode; int start; int slen; int per;
  } vec_t;

  int tests = 0, fails = 0, cyc = 0, exp_per = 0;
  logic [7:0]  m_idx [NCH];
  logic [7:0]  m_lfsr[NCH];
  int          m_cnt [NCH];
  int          rx_n  [NCH];
  int          n_done[NCH];
  bit          rx_act[NCH];
  int          rx_t  [NCH];
  logic [11:0] rx_bits[NCH];
  logic        prev_tx[NCH];
  int          last_start[NCH];
  bit          have_prev[NCH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] seed_of(input int c);
    logic [7:0] b;
    b = start + 8'(c);
    return (b == 8'd0) ? 8'h01 : b;
  endfunction

  // Successor under x^8+x^6+x^5+x^4+1: feedback is the XOR of the tapped stages
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    int   taps[4];
    logic fb;
    taps = '{8, 6, 5, 4};
    fb = 1'b0;
    for (int k = 0; k < 4; k++) fb ^= s[taps[k]-1];
    return {s[6:0], fb};
  endfunction

  task automatic next_byte(input int c, output logic [7:0] r);
    logic [7:0] b, last;
    b = start + 8'(c);
    case (mode)
      2'd1: begin r = m_lfsr[c]; m_lfsr[c] = lfsr_next(m_lfsr[c]); end
      2'd2: r = b;
      default: begin
        r = b + m_idx[c];
        last = (slen == 8'd0) ? 8'd0 : slen - 8'd1;
        m_idx[c] = (m_idx[c] == last) ? 8'd0 : m_idx[c] + 8'd1;
      end
    endcase
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_idx[c] = '0; m_lfsr[c] = seed_of(c); m_cnt[c] = 0; rx_n[c] = 0;
    end
  endtask

  task automatic finish_frame(input int c);
    logic [7:0]  e;
    logic [11:0] b;
    int          nb;
    bit          stop_ok;
    b  = rx_bits[c];
    nb = 10 + int'(pe) + int'(s2);
    next_byte(c, e);
    chk($sformatf("ch%0d start_bit", c), {31'd0, b[0]}, 32'd0);
    chk($sformatf("ch%0d data", c), {24'd0, b[8:1]}, {24'd0, e});
    if (pe) chk($sformatf("ch%0d parity", c), {31'd0, b[9]}, {31'd0, (^e) ^ po});
    stop_ok = 1'b1;
    for (int k = 9 + int'(pe); k < nb; k++) if (!b[k]) stop_ok = 1'b0;
    chk($sformatf("ch%0d stop_bits", c), {31'd0, stop_ok}, 32'd1);
    m_cnt[c]++;
    rx_n[c]++;
  endtask

  // Receiver: samples each line mid-bit using the bit time the bench configured
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        for (int c = 0; c < NCH; c++) begin
          rx_act[c] = 0; prev_tx[c] = 1'b1; have_prev[c] = 0; n_done[c] = 0;
        end
      end else begin
        for (int c = 0; c < NCH; c++) begin
          int dd, k;
          dd = (div < 16'd2) ? 2 : int'(div);
          if (done[c]) n_done[c]++;
          if (!rx_act[c]) begin
            if (prev_tx[c] && !tx[c]) begin
              rx_act[c] = 1; rx_t[c] = 0; rx_bits[c] = '0;
              if (have_prev[c] && exp_per != 0)
                chk($sformatf("ch%0d period", c), 32'(cyc - last_start[c]), 32'(exp_per));
              last_start[c] = cyc; have_prev[c] = 1;
            end
          end else rx_t[c]++;
          if (rx_act[c] && (rx_t[c] % dd) == dd / 2) begin
            k = rx_t[c] / dd;
            rx_bits[c][k] = tx[c];
            if (k == 9 + int'(pe) + int'(s2)) begin
              finish_frame(c);
              rx_act[c] = 0;
            end
          end
          prev_tx[c] = tx[c];
        end
      end
    end
  end

  task automatic set_cfg(input vec_t v);
    div = DW'(v.div); gap = GW'(v.gap); pe = v.pe; po = v.po; s2 = v.s2;
    start = 8'(v.start); slen = 8'(v.slen);
    if (v.mode == 1 && mode != 2'd1)
      for (int c = 0; c < NCH; c++) m_lfsr[c] = seed_of(c);
    mode = 2'(v.mode);
    exp_per = v.per;
    for (int c = 0; c < NCH; c++) have_prev[c] = 0;
  endtask

  task automatic wait_frames(input logic [NCH-1:0] mask, input int n);
    int tgt[NCH];
    bit ok;
    for (int c = 0; c < NCH; c++) tgt[c] = rx_n[c] + n;
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = 1;
      for (int c = 0; c < NCH; c++) if (mask[c] && rx_n[c] < tgt[c]) ok = 0;
    end
    chk("wait_frames in time", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (busy == '0) && !rx_act[0] && !rx_act[1];
    end
    chk("wait_idle in time", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_counts();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("ch%0d frame_cnt", c), {16'd0, fcnt[c*CW +: CW]}, 32'(m_cnt[c]) & 32'hFFFF);
      chk($sformatf("ch%0d frame_done pulses", c), 32'(n_done[c]), 32'(m_cnt[c]));
    end
  endtask

  task automatic run_phase(input vec_t v, input logic [NCH-1:0] mask, input int n);
    @(negedge clk); #1;
    set_cfg(v);
    en = mask;
    wait_frames(mask, n);
    en = '0;
    wait_idle();
    repeat (2) @(negedge clk);
    #1;
    check_counts();
  endtask

  vec_t vt[10];

  initial begin
    vec_t v;
    int   lows;
    bit   ok;
    vt[0] = '{4, 0, 0, 0, 0,  0, 'h41, 26, 40};
    vt[1] = '{4, 1, 1, 0, 0,  0, 'h41, 26, 44};
    vt[2] = '{4, 1, 0, 0, 0,  0, 'h41, 26, 44};
    vt[3] = '{4, 0, 0, 1, 10, 0, 'h41, 26, 54};
    vt[4] = '{0, 0, 0, 0, 0,  0, 'h41, 26, 20};
    vt[5] = '{1, 1, 0, 1, 0,  0, 'h41, 26, 24};
    vt[6] = '{3, 0, 0, 0, 5,  0, 'h30, 0,  35};
    vt[7] = '{5, 0, 0, 0, 0,  2, 'h7E, 4,  50};
    vt[8] = '{2, 0, 0, 0, 0,  3, 'h61, 3,  20};
    vt[9] = '{2, 0, 0, 0, 0,  1, 'hFF, 3,  20};

    model_reset();
    #13;
    chk("reset tx_o", 32'(tx), 32'h3);
    chk("reset busy_o", 32'(busy), 32'h0);
    chk("reset frame_done_o", 32'(done), 32'h0);
    chk("reset frame_cnt_o", 32'(fcnt), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Full 26-letter sequence plus wrap on ch0 in the first phase
    run_phase(vt[0], 2'b11, 28);
    for (int i = 1; i < 10; i++) run_phase(vt[i], 2'b11, 4);

    for (int r = 0; r < 6; r++) begin
      int dd;
      v.div = $urandom_range(0, 7); v.pe = 1'($urandom_range(0, 1));
      v.po = 1'($urandom_range(0, 1)); v.s2 = 1'($urandom_range(0, 1));
      v.gap = $urandom_range(0, 12); v.mode = $urandom_range(0, 3);
      v.start = $urandom_range(0, 255); v.slen = $urandom_range(0, 8);
      dd = (v.div < 2) ? 2 : v.div;
      v.per = dd * (10 + int'(v.pe) + int'(v.s2)) + v.gap;
      run_phase(v, 2'(($urandom_range(1, 3))), 3);
    end

    // en dropped during the 5th data bit: frame completes, line then stays idle
    @(negedge clk); #1;
    set_cfg(vt[0]);
    en = 2'b01;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); #1; ok = rx_act[0]; end
    chk("ch0 start seen", {31'd0, ok}, 32'd1);
    repeat (21) @(negedge clk);
    #1;
    en = 2'b00;
    wait_idle();
    check_counts();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (!tx[0] || busy[0]) lows++;
    end
    chk("ch0 idle after drop", 32'(lows), 32'd0);
    run_phase(vt[0], 2'b01, 2);

    // Async reset in the middle of DATA
    @(negedge clk); #1;
    set_cfg(vt[0]);
    en = 2'b11;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); #1; ok = rx_act[0]; end
    chk("ch0 start before reset", {31'd0, ok}, 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid-frame reset tx_o", 32'(tx), 32'h3);
    chk("mid-frame reset busy_o", 32'(busy), 32'h0);
    chk("mid-frame reset frame_done_o", 32'(done), 32'h0);
    chk("mid-frame reset frame_cnt_o", 32'(fcnt), 32'h0);
    en = '0;
    repeat (3) @(negedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    run_phase(vt[4], 2'b11, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
